// File: rtl/gups_pkg.sv
// Shared definitions for the GUPS run controller: run-state encoding and default sizes.
// No logic; imported by the lane gate and the controller top.
// No flow control of its own.
package gups_pkg;

    localparam int GUPS_NREQ  = 4;
    localparam int GUPS_CNT_W = 32;
    localparam int GUPS_CYC_W = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

endpackage

// File: rtl/gups_lane_gate.sv
// Per-engine request gate: tracks one in-flight transaction and counts completed writes.
// req_out is combinational from req_in (zero latency); inflight/count update on the next edge.
// An accepted request stays ungated until its rdy_in, so nothing is cut off mid-flight.
module gups_lane_gate
    import gups_pkg::*;
#(
    parameter int CNT_W = GUPS_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] target,
    input  logic             req_in,
    input  logic             wr_in,
    input  logic             rdy_in,
    output logic             req_out,
    output logic             inflight,
    output logic             upd,
    output logic             at_target
);

    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enable;

    always_comb begin
        enable     = run && (cnt_q < target);
        req_out    = req_in && (enable || inflight_q);
        upd        = rdy_in && wr_in && inflight_q;
        at_target  = (cnt_q >= target);

        // A completion retires the transaction even if the engine re-requests in the same cycle.
        inflight_d = inflight_q;
        if (rdy_in) begin
            inflight_d = 1'b0;
        end else if (req_out) begin
            inflight_d = 1'b1;
        end

        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (upd && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    assign inflight = inflight_q;

endmodule

// File: rtl/gups_run_ctrl.sv
// GUPS run controller: gates engine requests toward the memory arbiter for a fixed update count.
// Request gating is combinational; status counters and state update one cycle after the event.
// Engines see backpressure only as a held-low req_out; completions are never blocked.
module gups_run_ctrl
    import gups_pkg::*;
#(
    parameter int NREQ  = GUPS_NREQ,
    parameter int CNT_W = GUPS_CNT_W,
    parameter int CYC_W = GUPS_CYC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   n_updates,
    input  logic [NREQ-1:0]    req_in,
    input  logic [NREQ-1:0]    wr_in,
    input  logic [NREQ-1:0]    rdy_in,
    output logic [NREQ-1:0]    req_out,
    output logic [NREQ-1:0]    rdy_out,
    output logic               busy,
    output logic               done,
    output logic [CYC_W-1:0]   cycles,
    output logic [CNT_W+1:0]   total_updates
);

    run_state_t         state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic [CNT_W+1:0]   total_q, total_d;
    logic [CNT_W+1:0]   upd_sum;

    logic               launch;
    logic               run_en;
    logic               counting;
    logic [NREQ-1:0]    inflight;
    logic [NREQ-1:0]    upd;
    logic [NREQ-1:0]    at_target;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        gups_lane_gate #(
            .CNT_W(CNT_W)
        ) u_gate (
            .clk       (clk),
            .reset     (reset),
            .clear     (launch),
            .run       (run_en),
            .target    (target_q),
            .req_in    (req_in[g]),
            .wr_in     (wr_in[g]),
            .rdy_in    (rdy_in[g]),
            .req_out   (req_out[g]),
            .inflight  (inflight[g]),
            .upd       (upd[g]),
            .at_target (at_target[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
            ST_RUN:           if (abort || (&at_target)) state_d = ST_DRAIN;
            ST_DRAIN:         if (~|inflight) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        launch   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        run_en   = (state_q == ST_RUN);
        counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        busy     = counting;
        done     = (state_q == ST_DONE);
    end

    // Completions are summed in every state so late DRAIN writes still land in the total.
    always_comb begin
        upd_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            upd_sum = upd_sum + (CNT_W+2)'(upd[i]);
        end

        target_d = launch ? n_updates : target_q;

        cycles_d = cycles_q;
        if (launch) begin
            cycles_d = '0;
        end else if (counting && (cycles_q != '1)) begin
            cycles_d = cycles_q + CYC_W'(1);
        end

        total_d = launch ? '0 : (total_q + upd_sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= '0;
            cycles_q <= '0;
            total_q  <= '0;
        end else begin
            target_q <= target_d;
            cycles_q <= cycles_d;
            total_q  <= total_d;
        end
    end

    assign rdy_out       = rdy_in;
    assign cycles        = cycles_q;
    assign total_updates = total_q;

endmodule

// File: tb/tb_gups_run_ctrl.sv
// Directed bench for gups_run_ctrl: engine/arbiter environment, cycle model, literal checkpoints.
module tb_gups_run_ctrl;

    localparam int NREQ  = 4;
    localparam int CNT_W = 32;
    localparam int CYC_W = 48;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic               clk;
    logic               reset;
    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   n_updates;
    logic [NREQ-1:0]    req_in;
    logic [NREQ-1:0]    wr_in;
    logic [NREQ-1:0]    rdy_in;
    logic [NREQ-1:0]    req_out;
    logic [NREQ-1:0]    rdy_out;
    logic               busy;
    logic               done;
    logic [CYC_W-1:0]   cycles;
    logic [CNT_W+1:0]   total_updates;

    gups_run_ctrl #(.NREQ(NREQ), .CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .n_updates     (n_updates),
        .req_in        (req_in),
        .wr_in         (wr_in),
        .rdy_in        (rdy_in),
        .req_out       (req_out),
        .rdy_out       (rdy_out),
        .busy          (busy),
        .done          (done),
        .cycles        (cycles),
        .total_updates (total_updates)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment controls, written by the main sequence only.
    logic [NREQ-1:0] eng_on;
    logic [NREQ-1:0] hold_mask;
    logic            env_clear;
    int              lat;

    // Engine + arbiter: engines hold req until rdy, alternating read/write; arbiter answers after lat cycles.
    logic [NREQ-1:0] last_req;
    logic [NREQ-1:0] env_pend;
    logic [NREQ-1:0] env_wr;
    int              env_age [NREQ];

    initial begin
        req_in = '0; wr_in = '0; rdy_in = '0;
        env_pend = '0; env_wr = '0;
        for (int i = 0; i < NREQ; i++) env_age[i] = 0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (env_clear) begin
                    env_pend[i] = 1'b0;
                    env_age[i]  = 0;
                    env_wr[i]   = 1'b0;
                    rdy_in[i]   = 1'b0;
                    req_in[i]   = eng_on[i];
                    wr_in[i]    = 1'b0;
                end else begin
                    if (rdy_in[i]) begin
                        env_pend[i] = 1'b0;
                        env_wr[i]   = ~env_wr[i];
                    end
                    if (!env_pend[i] && last_req[i]) begin
                        env_pend[i] = 1'b1;
                        env_age[i]  = 0;
                    end
                    rdy_in[i] = 1'b0;
                    if (env_pend[i]) begin
                        env_age[i] = env_age[i] + 1;
                        if (env_age[i] == lat) rdy_in[i] = 1'b1;
                        req_in[i] = !rdy_in[i] || hold_mask[i];
                    end else begin
                        req_in[i] = eng_on[i];
                    end
                    wr_in[i] = env_wr[i];
                end
            end
        end
    end

    always @(negedge clk) last_req = req_out;

    // Cycle-level reference model of the run rules.
    int               m_mode;
    logic [CNT_W-1:0] m_target;
    logic [CNT_W-1:0] m_cnt [NREQ];
    logic [NREQ-1:0]  m_infl;
    logic [CYC_W-1:0] m_cycles;
    logic [CNT_W+1:0] m_total;
    bit               cmp_en;
    int               m_nup;
    bit               m_all_met;
    bit               m_any_infl;
    bit               m_rq;

    initial begin
        cmp_en = 1'b0;
        m_mode = M_IDLE; m_target = '0; m_infl = '0; m_cycles = '0; m_total = '0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_mode = M_IDLE; m_target = '0; m_infl = '0; m_cycles = '0; m_total = '0;
                for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
                cmp_en = 1'b1;
            end else begin
                m_nup = 0; m_all_met = 1'b1; m_any_infl = 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    m_rq = req_in[i] && (((m_mode == M_RUN) && (m_cnt[i] < m_target)) || m_infl[i]);
                    if (m_cnt[i] < m_target) m_all_met = 1'b0;
                    if (m_infl[i]) m_any_infl = 1'b1;
                    if (rdy_in[i] && wr_in[i] && m_infl[i]) begin
                        m_nup = m_nup + 1;
                        if (m_cnt[i] != '1) m_cnt[i] = m_cnt[i] + 1;
                    end
                    if (rdy_in[i]) m_infl[i] = 1'b0;
                    else if (m_rq) m_infl[i] = 1'b1;
                end
                m_total = m_total + (CNT_W+2)'(m_nup);
                case (m_mode)
                    M_IDLE, M_DONE: begin
                        if (start) begin
                            m_mode = M_RUN; m_target = n_updates; m_cycles = '0; m_total = '0;
                            for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
                        end
                    end
                    M_RUN: begin
                        if (m_cycles != '1) m_cycles = m_cycles + 1;
                        if (abort || m_all_met) m_mode = M_DRAIN;
                    end
                    default: begin
                        if (m_cycles != '1) m_cycles = m_cycles + 1;
                        if (!m_any_infl) m_mode = M_DONE;
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    logic [NREQ-1:0] exp_req;
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int i = 0; i < NREQ; i++)
                    exp_req[i] = req_in[i] && (((m_mode == M_RUN) && (m_cnt[i] < m_target)) || m_infl[i]);
                chk("req_out", 64'(req_out), 64'(exp_req));
                chk("rdy_out", 64'(rdy_out), 64'(rdy_in));
                chk("busy", 64'(busy), 64'((m_mode == M_RUN) || (m_mode == M_DRAIN)));
                chk("done", 64'(done), 64'(m_mode == M_DONE));
                chk("cycles", 64'(cycles), 64'(m_cycles));
                chk("total_updates", 64'(total_updates), 64'(m_total));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            tick();
            #3;
            if (done === 1'b1) break;
            k++;
        end
        chk("done_within_budget", 64'(done), 64'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; n_updates = '0;
        eng_on = '1; hold_mask = '0; env_clear = 1'b1; lat = 2;
        repeat (3) tick();
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        chk("rst_total", 64'(total_updates), 64'd0);
        chk("rst_req_out", 64'(req_out), 64'd0);
        tick(); reset = 1'b0; env_clear = 1'b0;

        // Target 3, read/write pairs on all lanes with 2-cycle rdy latency.
        tick(); n_updates = 32'd3; start = 1'b1;
        tick(); start = 1'b0;
        repeat (5) tick();
        #3 chk("s1_total_before_wr", 64'(total_updates), 64'd0);
        tick();
        #3 chk("s1_total_after_4wr", 64'(total_updates), 64'd4);
        repeat (12) tick();
        #3 chk("s1_gated_after_target", 64'(req_out), 64'd0);
        chk("s1_busy_at_target", 64'(busy), 64'd1);
        repeat (2) tick();
        #3 chk("s1_done", 64'(done), 64'd1);
        chk("s1_cycles", 64'(cycles), 64'd20);
        chk("s1_total", 64'(total_updates), 64'd12);

        // Target 0: one RUN cycle, one DRAIN cycle, no requests.
        tick(); env_clear = 1'b1; n_updates = 32'd0; start = 1'b1;
        tick(); start = 1'b0; env_clear = 1'b0;
        #3 chk("s2_busy_run", 64'(busy), 64'd1);
        chk("s2_no_req", 64'(req_out), 64'd0);
        tick();
        #3 chk("s2_busy_drain", 64'(busy), 64'd1);
        tick();
        #3 chk("s2_done", 64'(done), 64'd1);
        chk("s2_cycles", 64'(cycles), 64'd2);

        // Abort with reads in flight on lanes 0 and 2.
        tick(); env_clear = 1'b1; eng_on = 4'b0101; hold_mask = 4'b0001; lat = 5;
        n_updates = 32'd10; start = 1'b1;
        tick(); start = 1'b0; env_clear = 1'b0;
        tick();
        tick(); abort = 1'b1;
        tick(); abort = 1'b0; eng_on = 4'b1111;
        #3 chk("s3_drain_req", 64'(req_out), 64'b0101);
        tick();
        #3 chk("s3_drain_req2", 64'(req_out), 64'b0101);
        tick();
        #3 chk("s3_busy_on_rdy", 64'(busy), 64'd1);
        tick();
        #3 chk("s3_gated_after_rdy", 64'(req_out), 64'd0);
        tick();
        #3 chk("s3_done", 64'(done), 64'd1);
        chk("s3_cycles", 64'(cycles), 64'd7);
        chk("s3_total", 64'(total_updates), 64'd0);

        // Reset in the middle of a run with all lanes in flight.
        tick(); env_clear = 1'b1; eng_on = 4'b1111; hold_mask = '0; lat = 20;
        n_updates = 32'd10; start = 1'b1;
        tick(); start = 1'b0; env_clear = 1'b0;
        repeat (2) tick();
        #3 chk("s4_all_inflight", 64'(req_out), 64'hF);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; env_clear = 1'b1;
        #3 chk("s4_req_after_rst", 64'(req_out), 64'd0);
        chk("s4_busy_after_rst", 64'(busy), 64'd0);
        chk("s4_done_after_rst", 64'(done), 64'd0);
        chk("s4_cycles_after_rst", 64'(cycles), 64'd0);

        // Start during RUN is ignored; a restart from DONE clears and re-latches.
        lat = 2;
        tick(); n_updates = 32'd2; start = 1'b1;
        tick(); start = 1'b0; env_clear = 1'b0;
        repeat (2) tick();
        start = 1'b1; n_updates = 32'd7;
        tick(); start = 1'b0;
        wait_done(60);
        chk("s5_run1_total", 64'(total_updates), 64'd8);
        chk("s5_run1_cycles", 64'(cycles), 64'd14);
        tick(); env_clear = 1'b1; n_updates = 32'd5; start = 1'b1;
        tick(); start = 1'b0; env_clear = 1'b0;
        wait_done(80);
        chk("s5_run2_total", 64'(total_updates), 64'd20);
        chk("s5_run2_cycles", 64'(cycles), 64'd32);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
